qsys_nios2_qsys_0_jtag_ocimem_sequencer: RTL and testbench

Sysclk-domain controller that turns decoded JTAG debug actions (take_action_ocimem_a/b, take_no_action_ocimem_a, jdo) into single-word read/write transactions on the OCI debug-memory port. It keeps an auto-incrementing word address, times out stalled accesses, and returns read data plus status (MonDReg, monitor_ready, monitor_error) to the TCK-side scan chain. It sits between the debug action decoder and the on-chip debug ROM/RAM.

---
 rtl/qsys_nios2_qsys_0_jtag_ocimem_sequencer.sv | 96 +++++++++
 tb/tb_qsys_nios2_qsys_0_jtag_ocimem_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/qsys_nios2_qsys_0_jtag_ocimem_sequencer.sv
// qsys_nios2_qsys_0_jtag_ocimem_sequencer: turns JTAG debug commands into single-word OCI memory reads/writes
//   clk, reset_n                : system clock, async active-low reset
//   jdo, take_action_ocimem_a/b,
//   take_no_action_ocimem_a     : decoded debug commands and their shadow data
//   mem_*                       : debug memory port (held strobe, waitrequest handshake)
//   MonDReg, monitor_ready,
//   monitor_error, cmd_dropped  : status returned to the scan chain
module qsys_nios2_qsys_0_jtag_ocimem_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              cmd_dropped
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    localparam logic [16:0] TO = 17'(TIMEOUT);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, mon_q, mon_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d, drop_q, drop_d;
    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mon_d   = mon_q;
        err_d   = err_q;
        cnt_d   = cnt_q + 16'd1;
        drop_d  = (state_q != IDLE) &&
                  (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a);
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (take_action_ocimem_b) begin
                wdata_d = jdo[34:3];
                state_d = WR;
            end else if (take_action_ocimem_a) begin
                addr_d = jdo[17 +: ADDR_W];
                if (jdo[34]) err_d = 1'b0;
                if (jdo[35]) state_d = RD;
            end else if (take_no_action_ocimem_a) begin
                state_d = RD;
            end
        end else if (!mem_waitrequest) begin
            if (state_q == RD) mon_d = mem_readdata;
            addr_d  = addr_q + 1'b1;
            state_d = IDLE;
        end else if ({1'b0, cnt_q} + 17'd1 >= TO) begin
            // abort: no increment, no data capture
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mon_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end
    assign mem_address   = addr_q;
    assign mem_read      = state_q == RD;
    assign mem_write     = state_q == WR;
    assign mem_writedata = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = state_q == IDLE;
    assign monitor_error = err_q;
    assign cmd_dropped   = drop_q;
endmodule

// File: tb/tb_qsys_nios2_qsys_0_jtag_ocimem_sequencer.sv
// tb_qsys_nios2_qsys_0_jtag_ocimem_sequencer: cycle-by-cycle vector bench for the OCI memory sequencer
module tb_qsys_nios2_qsys_0_jtag_ocimem_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta = 1'b0, tb = 1'b0, tna = 1'b0;
    logic [8:0]  mem_address;
    logic        mem_read, mem_write, mem_waitrequest = 1'b0;
    logic [31:0] mem_writedata, mem_readdata = '0, MonDReg;
    logic        monitor_ready, monitor_error, cmd_dropped;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    qsys_nios2_qsys_0_jtag_ocimem_sequencer #(.ADDR_W(9), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_action_ocimem_b(tb), .take_no_action_ocimem_a(tna),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .cmd_dropped(cmd_dropped)
    );

    typedef struct {
        logic a, b, na;
        logic [37:0] jdo;
        logic wr;
        logic [31:0] rd;
        logic er, ew;
        logic [8:0] ea;
        logic erdy, eerr, edrop;
        logic [31:0] emon, ewd;
    } vec_t;
    vec_t tv[$];

    function automatic logic [37:0] ja(input logic [8:0] ad, input logic clr, input logic rd);
        logic [37:0] j;
        j = '0;
        j[25:17] = ad;
        j[34] = clr;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic add(input logic a, b, na, input logic [37:0] j, input logic w, input logic [31:0] rdd,
                       input logic er, ew, input logic [8:0] ea, input logic erdy, eerr, edrop,
                       input logic [31:0] emon, ewd);
        vec_t v;
        v.a = a; v.b = b; v.na = na; v.jdo = j; v.wr = w; v.rd = rdd;
        v.er = er; v.ew = ew; v.ea = ea; v.erdy = erdy; v.eerr = eerr; v.edrop = edrop;
        v.emon = emon; v.ewd = ewd;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        // read with load, zero wait
        add(0,0,0, '0,            0, 0,            0,0,9'h000,1,0,0, 32'h0,        32'h0);
        add(1,0,0, ja(9'h010,0,1),0, 0,            0,0,9'h000,1,0,0, 32'h0,        32'h0);
        add(0,0,0, '0,            0, 32'hDEADBEEF, 1,0,9'h010,0,0,0, 32'h0,        32'h0);
        add(0,0,0, '0,            0, 0,            0,0,9'h011,1,0,0, 32'hDEADBEEF, 32'h0);
        // load 0x1FE without read, then three read-next with wrap
        add(1,0,0, ja(9'h1FE,0,0),0, 0,            0,0,9'h011,1,0,0, 32'hDEADBEEF, 32'h0);
        add(0,0,1, '0,            0, 0,            0,0,9'h1FE,1,0,0, 32'hDEADBEEF, 32'h0);
        add(0,0,0, '0,            0, 32'h1,        1,0,9'h1FE,0,0,0, 32'hDEADBEEF, 32'h0);
        add(0,0,1, '0,            0, 0,            0,0,9'h1FF,1,0,0, 32'h1,        32'h0);
        add(0,0,0, '0,            0, 32'h2,        1,0,9'h1FF,0,0,0, 32'h1,        32'h0);
        add(0,0,1, '0,            0, 0,            0,0,9'h000,1,0,0, 32'h2,        32'h0);
        add(0,0,0, '0,            0, 32'h3,        1,0,9'h000,0,0,0, 32'h2,        32'h0);
        add(0,0,0, '0,            0, 0,            0,0,9'h001,1,0,0, 32'h3,        32'h0);
        // write with 3 wait cycles
        add(0,1,0, jb(32'h12345678),0,0,           0,0,9'h001,1,0,0, 32'h3,        32'h0);
        add(0,0,0, '0,            1, 0,            0,1,9'h001,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            0,1,9'h001,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            0,1,9'h001,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            0, 0,            0,1,9'h001,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            0, 0,            0,0,9'h002,1,0,0, 32'h3,        32'h12345678);
        // read stalls to timeout, then clear error
        add(0,0,1, '0,            0, 0,            0,0,9'h002,1,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            1,0,9'h002,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            1,0,9'h002,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            1,0,9'h002,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            1,0,9'h002,0,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            0,0,9'h002,1,1,0, 32'h3,        32'h12345678);
        add(1,0,0, ja(9'h002,1,0),0, 0,            0,0,9'h002,1,1,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            0, 0,            0,0,9'h002,1,0,0, 32'h3,        32'h12345678);
        // read-next during stalled write is dropped
        add(0,1,0, jb(32'hAABBCCDD),0,0,           0,0,9'h002,1,0,0, 32'h3,        32'h12345678);
        add(0,0,0, '0,            1, 0,            0,1,9'h002,0,0,0, 32'h3,        32'hAABBCCDD);
        add(0,0,1, '0,            1, 0,            0,1,9'h002,0,0,0, 32'h3,        32'hAABBCCDD);
        add(0,0,0, '0,            1, 0,            0,1,9'h002,0,0,1, 32'h3,        32'hAABBCCDD);
        add(0,0,0, '0,            0, 0,            0,1,9'h002,0,0,0, 32'h3,        32'hAABBCCDD);
        add(0,0,0, '0,            0, 0,            0,0,9'h003,1,0,0, 32'h3,        32'hAABBCCDD);
        add(0,0,0, '0,            0, 0,            0,0,9'h003,1,0,0, 32'h3,        32'hAABBCCDD);
        // b + a + no_action together: only the write runs
        add(1,1,1, jb(32'h0F0F0F0F) | (38'd1 << 35),0,0, 0,0,9'h003,1,0,0, 32'h3, 32'hAABBCCDD);
        add(0,0,0, '0,            0, 0,            0,1,9'h003,0,0,0, 32'h3,        32'h0F0F0F0F);
        add(0,0,0, '0,            0, 0,            0,0,9'h004,1,0,0, 32'h3,        32'h0F0F0F0F);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            ta = tv[i].a; tb = tv[i].b; tna = tv[i].na; jdo = tv[i].jdo;
            mem_waitrequest = tv[i].wr; mem_readdata = tv[i].rd;
            @(negedge clk);
            tests++;
            if ({mem_read, mem_write, mem_address, monitor_ready, monitor_error, cmd_dropped, MonDReg, mem_writedata} !==
                {tv[i].er, tv[i].ew, tv[i].ea, tv[i].erdy, tv[i].eerr, tv[i].edrop, tv[i].emon, tv[i].ewd}) begin
                fails++;
                $display("FAIL row %0d: got rd=%b wr=%b addr=%h rdy=%b err=%b drop=%b mon=%h wd=%h expected rd=%b wr=%b addr=%h rdy=%b err=%b drop=%b mon=%h wd=%h",
                         i, mem_read, mem_write, mem_address, monitor_ready, monitor_error, cmd_dropped, MonDReg, mem_writedata,
                         tv[i].er, tv[i].ew, tv[i].ea, tv[i].erdy, tv[i].eerr, tv[i].edrop, tv[i].emon, tv[i].ewd);
            end
        end

        // asynchronous reset in the middle of a stalled read
        @(posedge clk);
        #1 ta = 0; tb = 0; tna = 1; mem_waitrequest = 1'b1;
        @(posedge clk);
        #1 tna = 0;
        check("midrd_read", 32'(mem_read), 32'h1);
        check("midrd_addr", 32'(mem_address), 32'h004);
        #2 reset_n = 1'b0;
        #1;
        check("rst_read", 32'(mem_read), 32'h0);
        check("rst_ready", 32'(monitor_ready), 32'h1);
        check("rst_addr", 32'(mem_address), 32'h0);
        check("rst_mon", MonDReg, 32'h0);
        check("rst_wd", mem_writedata, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_read", 32'(mem_read), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
